// File: rtl/mult16_seq.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// a fixed 16-iteration RUN phase, and a one-cycle done pulse with held result.
module mult16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;

  logic            w_accept;
  logic [CW-1:0]   w_cnt_next;
  logic            w_last;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_acc_next;

  assign w_accept   = start && (r_state != S_RUN);
  assign w_cnt_next = r_cnt + CW'(1);
  assign w_last     = (w_cnt_next == CW'(WIDTH));
  assign w_addend   = r_mplier[0] ? r_mcand : {PW{1'b0}};
  // Accumulator is wide enough for the full product, so this add never wraps.
  assign w_acc_next = r_acc + w_addend;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; DONE with start high re-enters RUN without an idle cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they track the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_RUN);
      r_done <= (w_state_next == S_DONE);
    end
  end

  // Operand capture and one shift-add iteration per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= {PW{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (r_state == S_RUN) begin
      r_mcand  <= {r_mcand[PW-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_acc    <= w_acc_next;
      r_cnt    <= w_cnt_next;
    end else begin
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_acc    <= r_acc;
      r_cnt    <= r_cnt;
    end
  end

  // Result words change only when the final iteration completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_lo <= {WIDTH{1'b0}};
      r_res_hi <= {WIDTH{1'b0}};
    end else if ((r_state == S_RUN) && w_last) begin
      r_res_lo <= w_acc_next[WIDTH-1:0];
      r_res_hi <= w_acc_next[PW-1:WIDTH];
    end else begin
      r_res_lo <= r_res_lo;
      r_res_hi <= r_res_hi;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;

endmodule

// File: tb/tb_mult16_seq.sv
// Scoreboard bench for mult16_seq: stimulus pushes a*b with its accept cycle,
// a negedge monitor checks each done pulse, its latency and held results.
module tb_mult16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;

  typedef struct {
    logic [31:0] prod;
    int          k;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          bcnt     = 0;
  logic [31:0] held     = 32'h0;

  mult16_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: reset flushes expectations; done pops and checks; otherwise result must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        held = 32'h0;
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (done) begin
          chk("busy_low_in_done", {31'h0, busy}, 32'h0);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: done=1 expected no done (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("product", {result_hi, result_lo}, e.prod);
            chk("latency", 32'(cyc - e.k), 32'd16);
            chk("busy_cycles", 32'(bcnt), 32'd16);
            held = e.prod;
          end
          bcnt = 0;
        end else begin
          chk("result_held", {result_hi, result_lo}, held);
          if (sb.size() > 0 && cyc > sb[0].k + 16) begin
            checks++;
            failures++;
            $display("FAIL missing_done: no done by cycle %0d expected at %0d", cyc, sb[0].k + 16);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // Issue one multiply; inj>0 drives an ignored start (2*2) at that RUN cycle.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                       input int inj, input bit noise, input int gap);
    start = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk); #1;
    sb.push_back('{prod: 32'(ia) * 32'(ib), k: cyc});
    for (int i = 1; i <= 15; i++) begin
      if (i == inj) begin
        start = 1'b1; a = 16'h0002; b = 16'h0002;
      end else if (noise) begin
        start = 1'($urandom_range(0, 1)); a = 16'($urandom); b = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", {result_hi, result_lo}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("no_accept_under_rst", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;

    do_op(16'h0003, 16'h0005, 0, 1'b0, 1);
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0, 0);
    do_op(16'h1234, 16'h0000, 0, 1'b0, 2);
    do_op(16'h00AB, 16'h0CDE, 5, 1'b0, 0);
    do_op(16'h0100, 16'h0100, 0, 1'b0, 1);

    // Reset pulse mid-RUN, away from any clock edge.
    start = 1'b1; a = 16'h7777; b = 16'h9999;
    @(posedge clk); #1;
    sb.push_back('{prod: 32'h7777 * 32'h9999, k: cyc});
    start = 1'b0;
    repeat (7) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_result", {result_hi, result_lo}, 32'h0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    do_op(16'h0011, 16'h0022, 0, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 7 == 0) ra = 16'hFFFF;
      if (n % 9 == 0) rb = 16'h0000;
      do_op(ra, rb, 0, 1'b1, $urandom_range(0, 2));
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult16_seq.md
MULT16_SEQ -- requirements
Module: mult16_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; only 16 is supported and verified.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled on rising edge of clk.
REQ-005 SHALL have port a  input  16  unsigned multiplicand; sampled only on an accepted start.
REQ-006 SHALL have port b  input  16  unsigned multiplier; sampled only on an accepted start.
REQ-007 SHALL have port busy  output  1  high while an iteration is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking result valid.
REQ-009 SHALL have port result_lo  output  16  product bits [15:0]; feeds the downstream 16-bit zero/flag reduction stage.
REQ-010 SHALL have port result_hi  output  16  product bits [31:16]; overflow word.

Function
REQ-011 SHALL implement an unsigned 16x16 -> 32-bit shift-add multiplier, one multiplier bit per clock.
REQ-012 SHALL use three states: IDLE, RUN, DONE; encoding is free.
REQ-013 SHALL accept start only in IDLE or DONE; an accepted start captures a and b, clears the accumulator, loads a 5-bit iteration counter with 0, and enters RUN.
REQ-014 SHALL ignore start while in RUN; operands and progress unaffected.
REQ-015 SHALL in each RUN cycle add the shifted multiplicand to the 32-bit accumulator when the current multiplier LSB is 1, shift the multiplier right and the multiplicand left by one, and increment the counter.
REQ-016 SHALL leave RUN after exactly 16 iterations (counter reaching 16) and enter DONE; no early termination on a zero multiplier.
REQ-017 SHALL give fixed latency: start accepted at edge k -> done high for exactly the cycle following edge k+16.
REQ-018 SHALL drive busy = 1 exactly in RUN; done = 1 exactly in DONE.
REQ-019 SHALL update result_lo/result_hi only on the transition RUN -> DONE and hold them stable through DONE, IDLE and the next RUN until the next DONE.
REQ-020 SHALL return DONE -> IDLE after one cycle when start is low; DONE with start high goes directly to RUN (back-to-back, no idle cycle).
REQ-021 SHALL compute the exact 32-bit product; no truncation, saturation or wrap in the accumulator (max 0xFFFE0001).
REQ-022 SHALL not depend on a/b values outside the accepting edge; operand changes during RUN have no effect.

Reset
REQ-023 SHALL on rst high, immediately and regardless of clk, force state IDLE, busy 0, done 0, result_lo 0x0000, result_hi 0x0000, counter and accumulator 0.
REQ-024 SHALL abandon any in-flight multiply on reset mid-RUN; no done pulse is produced for it.
REQ-025 SHALL ignore start on any edge where rst is high; first accept possible on the first edge after rst deasserts.

Verification
REQ-026 SHALL cover basic: a=0x0003, b=0x0005, start 1 cycle -> busy 16 cycles, done pulse at edge k+16, result_hi=0x0000, result_lo=0x000F.
REQ-027 SHALL cover max operands: a=0xFFFF, b=0xFFFF -> result_hi=0xFFFE, result_lo=0x0001.
REQ-028 SHALL cover zero: a=0x1234, b=0x0000 -> still 16 busy cycles, result_hi=0x0000, result_lo=0x0000 (downstream zero flag asserts).
REQ-029 SHALL cover ignored start: start during RUN cycle 5 with a=0x0002, b=0x0002 -> original result unchanged, exactly one done pulse.
REQ-030 SHALL cover back-to-back: start held high in DONE with a=0x0100, b=0x0100 -> RUN entered next cycle, second done 16 cycles later, result_hi=0x0001, result_lo=0x0000; first result held until then.
REQ-031 SHALL cover reset mid-operation: rst pulsed asynchronously at RUN cycle 8 -> outputs zero immediately, no done, next start computes correctly.
